// File: rtl/nexi_uart_pkg.sv
// Shared definitions for the Wishbone FIFO UART: register map, bit positions, FSM states.
package nexi_uart_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_IER    = 3'd2;
  localparam logic [2:0] ADDR_ISR    = 3'd3;
  localparam logic [2:0] ADDR_DIV_LO = 3'd4;
  localparam logic [2:0] ADDR_DIV_HI = 3'd5;
  localparam logic [2:0] ADDR_RXCNT  = 3'd6;
  localparam logic [2:0] ADDR_TXCNT  = 3'd7;

  // STATUS bit positions
  localparam int unsigned ST_RX_NEMPTY = 0;
  localparam int unsigned ST_RX_FULL   = 1;
  localparam int unsigned ST_TX_EMPTY  = 2;
  localparam int unsigned ST_TX_FULL   = 3;
  localparam int unsigned ST_TX_BUSY   = 4;
  localparam int unsigned ST_RXOVR     = 5;
  localparam int unsigned ST_FERR      = 6;
  localparam int unsigned ST_TXOVF     = 7;

  // IER / ISR bit positions
  localparam int unsigned IE_RX_AVAIL = 0;
  localparam int unsigned IE_TX_DONE  = 1;
  localparam int unsigned IE_ERROR    = 2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/nexi_uart_sync_fifo.sv
// Synchronous FIFO with occupancy count; push and pop in the same cycle both take effect.
module nexi_uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array write
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers (wrap mod DEPTH) and occupancy count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nexi_uart_fifo_wb.sv
// Wishbone-slave 8N1 UART with TX/RX FIFOs, programmable baud divisor, sticky errors and IRQ.
module nexi_uart_fifo_wb
  import nexi_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd26
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cyc_i,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [2:0] addr_i,
  input  logic [7:0] data_i,
  output logic       ack_o,
  output logic [7:0] data_o,
  output logic       irq_o,
  input  logic       rx_pin,
  output logic       tx_pin
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          access, wr, rd, tx_push, rx_pop, isr_wr;
  logic [7:0]    rd_data, status;
  logic [2:0]    ier, pending;
  logic [15:0]   div, baud_cnt;
  logic          tick;
  logic          rxovr, ferr, txovf;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic [7:0]    tx_rdata, rx_rdata;

  tx_state_t     tx_state, tx_next;
  logic          tx_pop, tx_bit_done, tx_busy;
  logic [3:0]    tx_tcnt;
  logic [2:0]    tx_bcnt;
  logic [7:0]    tx_shr;

  rx_state_t     rx_state, rx_next;
  logic          rx_s1, rx_s2, rx_s3, rx_fall;
  logic          rx_mid, rx_bit_done, rx_push, ferr_set, rxovr_set;
  logic [3:0]    rx_tcnt;
  logic [2:0]    rx_bcnt;
  logic [7:0]    rx_shr;

  assign access  = cyc_i & stb_i & ~ack_o;
  assign wr      = access & we_i;
  assign rd      = access & ~we_i;
  assign tx_push = wr & (addr_i == ADDR_DATA);
  assign rx_pop  = rd & (addr_i == ADDR_DATA);
  assign isr_wr  = wr & (addr_i == ADDR_ISR);

  nexi_uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .push(tx_push), .pop(tx_pop), .wdata(data_i),
    .rdata(tx_rdata), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  nexi_uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .push(rx_push), .pop(rx_pop), .wdata(rx_shr),
    .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  assign tx_busy   = (tx_state != TX_IDLE);
  assign status    = {txovf, ferr, rxovr, tx_busy, tx_full, tx_empty, rx_full, ~rx_empty};
  assign pending   = {rxovr | ferr | txovf, tx_empty & ~tx_busy, ~rx_empty};
  assign rxovr_set = rx_push & rx_full & ~rx_pop;

  // Register read multiplexer
  always_comb begin
    rd_data = '0;
    case (addr_i)
      ADDR_DATA:   rd_data = rx_empty ? 8'h00 : rx_rdata;
      ADDR_STATUS: rd_data = status;
      ADDR_IER:    rd_data = {5'b0, ier};
      ADDR_ISR:    rd_data = {5'b0, pending};
      ADDR_DIV_LO: rd_data = div[7:0];
      ADDR_DIV_HI: rd_data = div[15:8];
      ADDR_RXCNT:  rd_data = 8'(rx_count);
      ADDR_TXCNT:  rd_data = 8'(tx_count);
      default:     rd_data = '0;
    endcase
  end

  // Bus handshake, control registers, sticky flags (hardware set beats W1C) and IRQ
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_o  <= 1'b0;
      data_o <= '0;
      irq_o  <= 1'b0;
      ier    <= '0;
      div    <= DIV_RESET;
      rxovr  <= 1'b0;
      ferr   <= 1'b0;
      txovf  <= 1'b0;
    end else begin
      ack_o  <= access;
      data_o <= rd ? rd_data : 8'h00;
      irq_o  <= |(pending & ier);
      if (wr && addr_i == ADDR_IER)    ier       <= data_i[2:0];
      if (wr && addr_i == ADDR_DIV_LO) div[7:0]  <= data_i;
      if (wr && addr_i == ADDR_DIV_HI) div[15:8] <= data_i;
      rxovr <= (rxovr & ~(isr_wr & data_i[ST_RXOVR])) | rxovr_set;
      ferr  <= (ferr  & ~(isr_wr & data_i[ST_FERR]))  | ferr_set;
      txovf <= (txovf & ~(isr_wr & data_i[ST_TXOVF])) | (tx_push & tx_full & ~tx_pop);
    end
  end

  // Baud down-counter: reloads DIV on zero, emitting one tick16 per DIV+1 cycles
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)             baud_cnt <= DIV_RESET;
    else if (baud_cnt == '0) baud_cnt <= div;
    else                     baud_cnt <= baud_cnt - 16'd1;
  end
  assign tick = (baud_cnt == '0);

  // TX state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tx_state <= TX_IDLE;
    else         tx_state <= tx_next;
  end

  // TX next state; frames start on a tick so every bit spans exactly 16 ticks
  always_comb begin
    tx_next     = tx_state;
    tx_pop      = 1'b0;
    tx_bit_done = tick && (tx_tcnt == 4'd15);
    case (tx_state)
      TX_IDLE:  if (tick && !tx_empty) begin
                  tx_next = TX_START;
                  tx_pop  = 1'b1;
                end
      TX_START: if (tx_bit_done) tx_next = TX_DATA;
      TX_DATA:  if (tx_bit_done && tx_bcnt == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_bit_done) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // TX datapath: tick counter, bit counter, shift register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_tcnt <= '0;
      tx_bcnt <= '0;
      tx_shr  <= '0;
    end else begin
      if (tx_state == TX_IDLE) tx_tcnt <= '0;
      else if (tick)           tx_tcnt <= tx_tcnt + 4'd1;
      if (tx_pop) begin
        tx_shr  <= tx_rdata;
        tx_bcnt <= '0;
      end else if (tx_state == TX_DATA && tx_bit_done) begin
        tx_shr  <= {1'b0, tx_shr[7:1]};
        tx_bcnt <= tx_bcnt + 3'd1;
      end
    end
  end

  assign tx_pin = (tx_state == TX_START) ? 1'b0 :
                  (tx_state == TX_DATA)  ? tx_shr[0] : 1'b1;

  // RX synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx_pin;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end
  assign rx_fall = rx_s3 & ~rx_s2;

  // RX state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rx_state <= RX_IDLE;
    else         rx_state <= rx_next;
  end

  // RX next state, glitch rejection, stop-bit check
  always_comb begin
    rx_next     = rx_state;
    rx_mid      = tick && (rx_tcnt == 4'd7);
    rx_bit_done = tick && (rx_tcnt == 4'd15);
    rx_push     = 1'b0;
    ferr_set    = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_mid) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_bit_done && rx_bcnt == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_bit_done) begin
                  rx_next  = RX_IDLE;
                  ferr_set = ~rx_s2;
                  rx_push  = rx_s2;
                end
      default:  rx_next = RX_IDLE;
    endcase
  end

  // RX datapath; the tick counter restarts at the start-bit centre so data samples land mid-bit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_tcnt <= '0;
      rx_bcnt <= '0;
      rx_shr  <= '0;
    end else begin
      case (rx_state)
        RX_IDLE:  begin
                    rx_tcnt <= '0;
                    rx_bcnt <= '0;
                  end
        RX_START: if (rx_mid) rx_tcnt <= '0;
                  else if (tick) rx_tcnt <= rx_tcnt + 4'd1;
        default:  if (tick) rx_tcnt <= rx_tcnt + 4'd1;
      endcase
      if (rx_state == RX_DATA && rx_bit_done) begin
        rx_shr  <= {rx_s2, rx_shr[7:1]};
        rx_bcnt <= rx_bcnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_nexi_uart_fifo_wb.sv
// Self-checking bench for nexi_uart_fifo_wb: bus register access, TX framing, RX, FIFOs, flags, IRQ.
module tb_nexi_uart_fifo_wb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cyc, stb, we;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic       ack;
  logic [7:0] rdata;
  logic       irq;
  logic       rx_line;
  logic       tx_pin;
  logic       rx_drv;
  logic       loop_en;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  assign rx_line = loop_en ? tx_pin : rx_drv;

  always #5 clk = ~clk;

  nexi_uart_fifo_wb #(.FIFO_DEPTH(16), .DIV_RESET(16'd26)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .addr_i(addr), .data_i(wdata), .ack_o(ack), .data_o(rdata), .irq_o(irq),
    .rx_pin(rx_line), .tx_pin(tx_pin)
  );

  task automatic clocks(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc = 0; stb = 0; we = 0; addr = '0; wdata = '0;
    rx_drv = 1'b1; loop_en = 1'b0;
    rst_n = 1'b0;
    #23;
    @(negedge clk) rst_n = 1'b1;
    clocks(2);
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
    bit ok = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; addr = a; wdata = d;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin ok = 1; break; end
    end
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
    if (!ok) begin
      total_cnt++;
      $display("FAIL wb_write_ack addr=%0d got=no-ack expected=ack", a);
    end
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [7:0] d);
    bit ok = 0;
    d = 8'hxx;
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; addr = a;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin ok = 1; d = rdata; break; end
    end
    @(negedge clk);
    cyc = 0; stb = 0;
    if (!ok) begin
      total_cnt++;
      $display("FAIL wb_read_ack addr=%0d got=no-ack expected=ack", a);
    end
  endtask

  task automatic set_div(input logic [15:0] v, input int unsigned settle);
    wb_write(3'd4, v[7:0]);
    wb_write(3'd5, v[15:8]);
    clocks(settle);
  endtask

  // Drive one 8N1 frame on rx_pin at bitclk clocks per bit
  task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned bitclk);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk) rx_drv = bits[k];
      repeat (bitclk - 1) @(negedge clk);
    end
    @(negedge clk) rx_drv = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    do_reset();
    total_cnt++;
    if (irq !== 1'b0 || tx_pin !== 1'b1) $display("FAIL reset_pins got irq=%b tx=%b expected irq=0 tx=1", irq, tx_pin);
    else pass_cnt++;
    wb_read(3'd1, v); total_cnt++;
    if (v !== 8'h04) $display("FAIL reset_status got=%h expected=04", v); else pass_cnt++;
    wb_read(3'd4, v); total_cnt++;
    if (v !== 8'd26) $display("FAIL reset_div_lo got=%0d expected=26", v); else pass_cnt++;
    wb_read(3'd5, v); total_cnt++;
    if (v !== 8'd0) $display("FAIL reset_div_hi got=%0d expected=0", v); else pass_cnt++;
    wb_read(3'd2, v); total_cnt++;
    if (v !== 8'h00) $display("FAIL reset_ier got=%h expected=00", v); else pass_cnt++;
    wb_read(3'd3, v); total_cnt++;
    if (v !== 8'h02) $display("FAIL reset_isr got=%h expected=02", v); else pass_cnt++;
    wb_read(3'd0, v); total_cnt++;
    if (v !== 8'h00) $display("FAIL reset_empty_read got=%h expected=00", v); else pass_cnt++;
  endtask

  task automatic test_regs();
    logic [7:0]  v;
    logic [15:0] d;
    logic [7:0]  ie;
    for (int i = 0; i < 4; i++) begin
      d = 16'($urandom);
      wb_write(3'd4, d[7:0]);
      wb_write(3'd5, d[15:8]);
      wb_read(3'd4, v); total_cnt++;
      if (v !== d[7:0]) $display("FAIL div_lo_rw got=%h expected=%h", v, d[7:0]); else pass_cnt++;
      wb_read(3'd5, v); total_cnt++;
      if (v !== d[15:8]) $display("FAIL div_hi_rw got=%h expected=%h", v, d[15:8]); else pass_cnt++;
      ie = 8'($urandom);
      wb_write(3'd2, ie);
      wb_read(3'd2, v); total_cnt++;
      if (v !== {5'b0, ie[2:0]}) $display("FAIL ier_rw got=%h expected=%h", v, {5'b0, ie[2:0]}); else pass_cnt++;
    end
  endtask

  task automatic test_tx_frame();
    logic [7:0] v, b;
    logic [9:0] bits;
    int unsigned bad;
    bit found;
    do_reset();
    set_div(16'd0, 40);
    for (int f = 0; f < 2; f++) begin
      b = (f == 0) ? 8'h55 : 8'($urandom);
      bits = {1'b1, b, 1'b0};
      wb_write(3'd0, b);
      found = 0;
      for (int i = 0; i < 100; i++) begin
        if (tx_pin === 1'b0) begin found = 1; break; end
        clocks(1);
      end
      total_cnt++;
      if (!found) begin
        $display("FAIL tx_start_timeout got=no-start expected=start");
        continue;
      end
      pass_cnt++;
      for (int k = 0; k < 10; k++) begin
        bad = 0;
        for (int j = 0; j < 16; j++) begin
          if (tx_pin !== bits[k]) bad++;
          clocks(1);
        end
        total_cnt++;
        if (bad != 0) $display("FAIL tx_bit%0d byte=%h got=%0d-bad-samples expected=0 level=%b", k, b, bad, bits[k]);
        else pass_cnt++;
      end
      wb_read(3'd1, v); total_cnt++;
      if (v !== 8'h04) $display("FAIL tx_done_status got=%h expected=04", v); else pass_cnt++;
    end
  endtask

  task automatic test_loopback();
    logic [7:0] v, b;
    logic [7:0] model[$];
    logic [7:0] fixed [4];
    fixed[0] = 8'hA5; fixed[1] = 8'h3C; fixed[2] = 8'h00; fixed[3] = 8'hFF;
    do_reset();
    set_div(16'd0, 40);
    loop_en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      int unsigned n = (r == 0) ? 4 : 8;
      for (int i = 0; i < int'(n); i++) begin
        b = (r == 0) ? fixed[i] : 8'($urandom);
        model.push_back(b);
        wb_write(3'd0, b);
      end
      clocks(n * 170 + 100);
      wb_read(3'd6, v); total_cnt++;
      if (v !== 8'(model.size())) $display("FAIL loop_rxcnt got=%0d expected=%0d", v, model.size()); else pass_cnt++;
      while (model.size() > 0) begin
        b = model.pop_front();
        wb_read(3'd0, v); total_cnt++;
        if (v !== b) $display("FAIL loop_data got=%h expected=%h", v, b); else pass_cnt++;
      end
      wb_read(3'd0, v); total_cnt++;
      if (v !== 8'h00) $display("FAIL loop_empty_read got=%h expected=00", v); else pass_cnt++;
    end
  endtask

  task automatic test_tx_overflow();
    logic [7:0] v;
    int unsigned exp_cnt = 0;
    bit exp_ovf = 0;
    do_reset();
    set_div(16'hFFFF, 300);
    for (int i = 0; i < 17; i++) begin
      wb_write(3'd0, 8'($urandom));
      if (exp_cnt < 16) exp_cnt++; else exp_ovf = 1;
    end
    wb_read(3'd7, v); total_cnt++;
    if (v !== 8'(exp_cnt)) $display("FAIL txcnt_sat got=%0d expected=%0d", v, exp_cnt); else pass_cnt++;
    wb_read(3'd1, v); total_cnt++;
    if (v !== {exp_ovf, 7'h08}) $display("FAIL txovf_status got=%h expected=%h", v, {exp_ovf, 7'h08}); else pass_cnt++;
    wb_read(3'd3, v); total_cnt++;
    if (v !== 8'h04) $display("FAIL txovf_isr got=%h expected=04", v); else pass_cnt++;
    wb_write(3'd3, 8'h80);
    wb_read(3'd1, v); total_cnt++;
    if (v !== 8'h08) $display("FAIL txovf_clear got=%h expected=08", v); else pass_cnt++;
    wb_read(3'd7, v); total_cnt++;
    if (v !== 8'd16) $display("FAIL txcnt_after_clear got=%0d expected=16", v); else pass_cnt++;
  endtask

  task automatic test_rx_overflow();
    logic [7:0] v, b;
    logic [7:0] model[$];
    bit ovr = 0;
    do_reset();
    set_div(16'd0, 40);
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 16);
      clocks(4);
      if (model.size() < 16) model.push_back(b); else ovr = 1;
    end
    clocks(20);
    wb_read(3'd6, v); total_cnt++;
    if (v !== 8'(model.size())) $display("FAIL rxovr_rxcnt got=%0d expected=%0d", v, model.size()); else pass_cnt++;
    wb_read(3'd1, v); total_cnt++;
    if (v !== {2'b00, ovr, 5'h07}) $display("FAIL rxovr_status got=%h expected=%h", v, {2'b00, ovr, 5'h07}); else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL rxovr_irq_masked got=%b expected=0", irq); else pass_cnt++;
    wb_write(3'd2, 8'h04);
    clocks(2); total_cnt++;
    if (irq !== 1'b1) $display("FAIL rxovr_irq_set got=%b expected=1", irq); else pass_cnt++;
    wb_write(3'd3, 8'h20);
    clocks(1); total_cnt++;
    if (irq !== 1'b0) $display("FAIL rxovr_irq_clear got=%b expected=0", irq); else pass_cnt++;
    wb_read(3'd1, v); total_cnt++;
    if (v !== 8'h07) $display("FAIL rxovr_cleared got=%h expected=07", v); else pass_cnt++;
    while (model.size() > 0) begin
      b = model.pop_front();
      wb_read(3'd0, v); total_cnt++;
      if (v !== b) $display("FAIL rxovr_data got=%h expected=%h", v, b); else pass_cnt++;
    end
  endtask

  task automatic test_ferr_glitch();
    logic [7:0] v, b;
    do_reset();
    set_div(16'd0, 40);
    send_frame(8'($urandom), 1'b0, 16);
    clocks(20);
    wb_read(3'd1, v); total_cnt++;
    if (v !== 8'h44) $display("FAIL ferr_status got=%h expected=44", v); else pass_cnt++;
    wb_read(3'd6, v); total_cnt++;
    if (v !== 8'd0) $display("FAIL ferr_rxcnt got=%0d expected=0", v); else pass_cnt++;
    wb_write(3'd3, 8'h40);
    wb_read(3'd1, v); total_cnt++;
    if (v !== 8'h04) $display("FAIL ferr_clear got=%h expected=04", v); else pass_cnt++;
    @(negedge clk) rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    clocks(300);
    wb_read(3'd6, v); total_cnt++;
    if (v !== 8'd0) $display("FAIL glitch_rxcnt got=%0d expected=0", v); else pass_cnt++;
    wb_read(3'd1, v); total_cnt++;
    if (v !== 8'h04) $display("FAIL glitch_status got=%h expected=04", v); else pass_cnt++;
    b = 8'($urandom);
    send_frame(b, 1'b1, 16);
    clocks(20);
    wb_read(3'd0, v); total_cnt++;
    if (v !== b) $display("FAIL post_glitch_data got=%h expected=%h", v, b); else pass_cnt++;
    wb_write(3'd2, 8'h02);
    clocks(2); total_cnt++;
    if (irq !== 1'b1) $display("FAIL tx_done_irq got=%b expected=1", irq); else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] v;
    bit found = 0;
    do_reset();
    set_div(16'd0, 40);
    wb_write(3'd0, 8'h00);
    for (int i = 0; i < 100; i++) begin
      if (tx_pin === 1'b0) begin found = 1; break; end
      clocks(1);
    end
    clocks(40);
    #2 rst_n = 1'b0;
    #1 total_cnt++;
    if (!found || tx_pin !== 1'b1) $display("FAIL midframe_reset_tx got=%b started=%0d expected=1", tx_pin, found);
    else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    clocks(2);
    wb_read(3'd1, v); total_cnt++;
    if (v !== 8'h04) $display("FAIL midframe_status got=%h expected=04", v); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_regs();
    test_tx_frame();
    test_loopback();
    test_tx_overflow();
    test_rx_overflow();
    test_ferr_glitch();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
